// File: rtl/amm_burst_master.sv
// Avalon-MM burst master: writes a seed+k incrementing pattern, or reads a burst back
// and checks it against the same pattern, reporting mismatch count and first bad address.
module amm_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command side
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_op_i,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [BURST_W-1:0]    cmd_len_i,
  input  logic [DATA_W-1:0]     cmd_seed_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  // Avalon-MM master side
  output logic [ADDR_W-1:0]     address_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [DATA_W-1:0]     writedata_o,
  output logic [DATA_W/8-1:0]   byteenable_o,
  output logic [BURST_W-1:0]    burstcount_o,
  input  logic                  waitrequest_i,
  input  logic [DATA_W-1:0]     readdata_i,
  input  logic                  readdatavalid_i,
  // debug: current FSM state
  output logic [2:0]            state_o
);

  // Handshakes: a command transfers on a rising edge with cmd_valid_i && cmd_ready_o;
  // a bus beat/command transfers on a rising edge with (write_o || read_o) && !waitrequest_i;
  // a read beat is taken on any rising edge with readdatavalid_i while in S_RD_DATA.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_CMD  = 3'd2,
    S_RD_DATA = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  len_q;
  logic [BURST_W-1:0]  beat;
  logic [DATA_W-1:0]   exp_q;
  logic                last_beat;

  assign state_o   = state;
  assign last_beat = (beat == len_q - BURST_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cmd_ready_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      err_cnt_o    <= '0;
      err_addr_o   <= '0;
      address_o    <= '0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      writedata_o  <= '0;
      byteenable_o <= '0;
      burstcount_o <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat         <= '0;
      exp_q        <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            addr_q      <= cmd_addr_i;
            len_q       <= cmd_len_i;
            beat        <= '0;
            exp_q       <= cmd_seed_i;
            writedata_o <= cmd_seed_i;
            if (cmd_op_i) begin
              err_o      <= 1'b0;
              err_cnt_o  <= '0;
              err_addr_o <= '0;
            end
            if (cmd_len_i == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              address_o    <= cmd_addr_i;
              burstcount_o <= cmd_len_i;
              byteenable_o <= '1;
              if (cmd_op_i) begin
                state  <= S_RD_CMD;
                read_o <= 1'b1;
              end else begin
                state   <= S_WR;
                write_o <= 1'b1;
              end
            end
          end
        end

        S_WR: begin
          if (!waitrequest_i) begin
            if (last_beat) begin
              write_o      <= 1'b0;
              byteenable_o <= '0;
              state        <= S_DONE;
              done_o       <= 1'b1;
            end else begin
              beat        <= beat + BURST_W'(1);
              writedata_o <= writedata_o + DATA_W'(1);
            end
          end
        end

        S_RD_CMD: begin
          if (!waitrequest_i) begin
            read_o       <= 1'b0;
            byteenable_o <= '0;
            state        <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (readdatavalid_i) begin
            if (readdata_i != exp_q) begin
              if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
              // only the first bad beat of the burst records its address
              if (!err_o) err_addr_o <= addr_q + ADDR_W'(beat);
              err_o <= 1'b1;
            end
            beat  <= beat + BURST_W'(1);
            exp_q <= exp_q + DATA_W'(1);
            if (last_beat) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state       <= S_IDLE;
          cmd_ready_o <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amm_burst_master.sv
// Directed bench for amm_burst_master: a bus-level model (expected write-beat queue,
// read-error model) is checked every cycle, plus hand-computed literal checks per test.
module tb_amm_burst_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                cmd_valid_i = 1'b0;
  logic                cmd_ready_o;
  logic                cmd_op_i = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr_i = '0;
  logic [BURST_W-1:0]  cmd_len_i = '0;
  logic [DATA_W-1:0]   cmd_seed_i = '0;
  logic                done_o, err_o;
  logic [15:0]         err_cnt_o;
  logic [ADDR_W-1:0]   err_addr_o, address_o;
  logic                read_o, write_o;
  logic [DATA_W-1:0]   writedata_o;
  logic [DATA_W/8-1:0] byteenable_o;
  logic [BURST_W-1:0]  burstcount_o;
  logic                waitrequest_i = 1'b0;
  logic [DATA_W-1:0]   readdata_i = '0;
  logic                readdatavalid_i = 1'b0;
  logic [2:0]          state_o;

  amm_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_seed_i(cmd_seed_i),
    .done_o(done_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .writedata_o(writedata_o),
    .byteenable_o(byteenable_o), .burstcount_o(burstcount_o), .waitrequest_i(waitrequest_i),
    .readdata_i(readdata_i), .readdatavalid_i(readdatavalid_i), .state_o(state_o)
  );

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] exp_q[$];       // write beats still expected on the bus
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [BURST_W-1:0] cur_len = '0;
  logic rd_pending = 1'b0;           // read command expected on the bus
  logic rd_active = 1'b0;            // read data beats expected
  logic              m_err = 1'b0;
  logic [15:0]       m_cnt = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ADDR_W-1:0] m_start = '0;
  logic [DATA_W-1:0] m_seed = '0;
  int m_beat = 0;
  int m_len = 0;

  int wr_acc = 0, wr_high = 0, hold_cnt = 0, last_acc_cyc = 0, first_wr_cyc = -1;
  int done_cnt = 0, done_cyc = 0, last_beat_cyc = 0;
  logic [DATA_W-1:0] hold_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("err_o", {63'd0, err_o}, {63'd0, m_err});
      chk("err_cnt", {48'd0, err_cnt_o}, {48'd0, m_cnt});
      chk("err_addr", {32'd0, err_addr_o}, {32'd0, m_addr});
      chk("byteenable", {60'd0, byteenable_o}, (write_o || read_o) ? 64'hF : 64'h0);
      if (write_o) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        wr_high++;
        if (writedata_o == hold_val) hold_cnt++;
        if (exp_q.size() == 0) fail("unexpected_write");
        else begin
          chk("writedata", {32'd0, writedata_o}, {32'd0, exp_q[0]});
          chk("wr_address", {32'd0, address_o}, {32'd0, cur_addr});
          chk("wr_burstcount", {53'd0, burstcount_o}, {53'd0, cur_len});
          if (!waitrequest_i) begin
            void'(exp_q.pop_front());
            wr_acc++;
            last_acc_cyc = cyc;
          end
        end
      end
      if (read_o) begin
        if (!rd_pending) fail("unexpected_read");
        else begin
          chk("rd_address", {32'd0, address_o}, {32'd0, cur_addr});
          chk("rd_burstcount", {53'd0, burstcount_o}, {53'd0, cur_len});
          if (!waitrequest_i) begin
            rd_pending = 1'b0;
            rd_active = 1'b1;
          end
        end
      end
      // beat presented now is consumed at the next edge; model reflects it from then on
      if (rd_active && readdatavalid_i) begin
        if (readdata_i != m_seed + DATA_W'(m_beat)) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (!m_err) m_addr = m_start + ADDR_W'(m_beat);
          m_err = 1'b1;
        end
        m_beat++;
        last_beat_cyc = cyc;
        if (m_beat == m_len) rd_active = 1'b0;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk("ready_low_in_done", {63'd0, cmd_ready_o}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic op, input logic [ADDR_W-1:0] addr,
                       input logic [BURST_W-1:0] len, input logic [DATA_W-1:0] seed,
                       output int acc);
    int guard = 0;
    while (!cmd_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready_o) fail("ready_timeout");
    cmd_valid_i = 1'b1;
    cmd_op_i = op;
    cmd_addr_i = addr;
    cmd_len_i = len;
    cmd_seed_i = seed;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    acc = cyc;
    cur_addr = addr;
    cur_len = len;
    if (!op) begin
      for (int k = 0; k < int'(len); k++) exp_q.push_back(seed + DATA_W'(k));
    end else begin
      m_err = 1'b0; m_cnt = '0; m_addr = '0;
      m_start = addr; m_seed = seed; m_beat = 0; m_len = int'(len);
      rd_pending = (len != '0);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] len,
                          input logic [DATA_W-1:0] seed, input int stall_beat,
                          input int stall_n, output int acc);
    int d0 = done_cnt;
    int left = stall_n;
    int guard = 0;
    wr_acc = 0; wr_high = 0; hold_cnt = 0; first_wr_cyc = -1;
    hold_val = seed + DATA_W'(1);
    issue(1'b0, addr, len, seed, acc);
    while (done_cnt == d0 && guard < 200) begin
      waitrequest_i = (wr_acc == stall_beat && left > 0);
      if (waitrequest_i) left--;
      readdatavalid_i = (guard == 1);   // stray beat: must be ignored outside a read
      readdata_i = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      guard++;
    end
    waitrequest_i = 1'b0;
    readdatavalid_i = 1'b0;
    if (done_cnt == d0) fail("wr_done_timeout");
    chk("wr_one_done", done_cnt, d0 + 1);
    chk("wr_beats", wr_acc, {53'd0, len});
    chk("wr_queue_empty", exp_q.size(), 0);
    if (len == '0) chk("zero_len_done_cycle", done_cyc, acc);
    else chk("wr_done_cycle", done_cyc, last_acc_cyc + 1);
    chk("ready_after_done", {63'd0, cmd_ready_o}, 64'd1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] len,
                         input logic [DATA_W-1:0] seed, input logic [15:0] corrupt,
                         input int cmd_stall, output int acc);
    int d0 = done_cnt;
    int guard = 0;
    issue(1'b1, addr, len, seed, acc);
    if (len != '0) begin
      for (int s = 0; s < cmd_stall; s++) begin
        waitrequest_i = 1'b1;
        @(posedge clk); #1;
      end
      waitrequest_i = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < int'(len); k++) begin
        for (int g = 0; g < k % 3; g++) begin
          waitrequest_i = 1'b1;           // no bus request pending: ignored
          @(posedge clk); #1;
        end
        waitrequest_i = 1'b0;
        readdatavalid_i = 1'b1;
        readdata_i = (seed + DATA_W'(k)) ^ (corrupt[k] ? 32'h0000_0100 : 32'h0);
        @(posedge clk); #1;
        readdatavalid_i = 1'b0;
      end
    end
    while (done_cnt == d0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (done_cnt == d0) fail("rd_done_timeout");
    chk("rd_one_done", done_cnt, d0 + 1);
    if (len == '0) chk("zero_len_done_cycle", done_cyc, acc);
    else chk("rd_done_cycle", done_cyc, last_beat_cyc + 1);
    chk("rd_beats_seen", m_beat, {53'd0, len});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int d0;
    int guard;

    #3;
    chk("rst_ready", {63'd0, cmd_ready_o}, 64'd0);
    chk("rst_write", {63'd0, write_o}, 64'd0);
    chk("rst_read", {63'd0, read_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_err_cnt", {48'd0, err_cnt_o}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {63'd0, cmd_ready_o}, 64'd1);

    // write 0x100 len 4 seed A000_0000, no stalls
    do_write(32'h100, 11'd4, 32'hA000_0000, -1, 0, acc);
    chk("t1_first_write_cycle", first_wr_cyc, acc);
    chk("t1_write_high_cycles", wr_high, 4);
    chk("t1_done_latency", done_cyc - acc, 4);

    // write len 3, two stall cycles on beat 1
    do_write(32'h40, 11'd3, 32'h10, 1, 2, acc);
    chk("t2_beat1_held", hold_cnt, 3);
    chk("t2_write_high_cycles", wr_high, 5);
    chk("t2_done_latency", done_cyc - acc, 5);

    // clean read 0x20 len 8 seed 5 with data gaps and a 2-cycle command stall
    do_read(32'h20, 11'd8, 32'd5, 16'h0000, 2, acc);
    chk("t3_err_o", {63'd0, err_o}, 64'd0);
    chk("t3_err_cnt", {48'd0, err_cnt_o}, 64'd0);

    // read with beats 2 and 6 corrupted
    do_read(32'h20, 11'd8, 32'd5, 16'h0044, 0, acc);
    chk("t4_err_o", {63'd0, err_o}, 64'd1);
    chk("t4_err_cnt", {48'd0, err_cnt_o}, 64'd2);
    chk("t4_err_addr", {32'd0, err_addr_o}, 64'h22);

    // a write leaves error outputs alone
    do_write(32'h300, 11'd2, 32'h77, -1, 0, acc);
    chk("t5_err_o_kept", {63'd0, err_o}, 64'd1);
    chk("t5_err_cnt_kept", {48'd0, err_cnt_o}, 64'd2);
    chk("t5_err_addr_kept", {32'd0, err_addr_o}, 64'h22);

    // next read clears them
    do_read(32'h500, 11'd4, 32'h1234, 16'h0000, 0, acc);
    chk("t6_err_cleared", {48'd0, err_cnt_o}, 64'd0);

    // zero-length commands: no bus activity, done right after acceptance
    do_write(32'h80, 11'd0, 32'h0, -1, 0, acc);
    do_read(32'h80, 11'd0, 32'h0, 16'h0000, 0, acc);

    // address wrap on the first bad beat, data wrap on the seed, stall on the last write beat
    do_read(32'hFFFF_FFFE, 11'd4, 32'hFFFF_FFFF, 16'h0008, 1, acc);
    chk("t7_wrap_err_addr", {32'd0, err_addr_o}, 64'h1);
    chk("t7_wrap_err_cnt", {48'd0, err_cnt_o}, 64'd1);
    do_write(32'h900, 11'd5, 32'hFFFF_FFFE, 4, 3, acc);
    chk("t8_done_latency", done_cyc - acc, 8);

    // reset in the middle of a 6-beat write, after two beats
    d0 = done_cnt;
    wr_acc = 0;
    issue(1'b0, 32'hC00, 11'd6, 32'h5555_0000, acc);
    guard = 0;
    while (wr_acc < 2 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("t9_beats_before_reset", wr_acc, 2);
    rst_n = 1'b0;
    #1;
    chk("t9_rst_write", {63'd0, write_o}, 64'd0);
    chk("t9_rst_be", {60'd0, byteenable_o}, 64'd0);
    chk("t9_rst_wdata", {32'd0, writedata_o}, 64'd0);
    chk("t9_rst_address", {32'd0, address_o}, 64'd0);
    chk("t9_rst_burstcount", {53'd0, burstcount_o}, 64'd0);
    chk("t9_rst_ready", {63'd0, cmd_ready_o}, 64'd0);
    chk("t9_rst_err_o", {63'd0, err_o}, 64'd0);
    exp_q.delete();
    rd_pending = 1'b0; rd_active = 1'b0;
    m_err = 1'b0; m_cnt = '0; m_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t9_ready_after_release", {63'd0, cmd_ready_o}, 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("t9_no_done_after_reset", done_cnt, d0);

    // normal operation resumes
    do_read(32'h40, 11'd3, 32'h10, 16'h0001, 0, acc);
    chk("t10_err_addr", {32'd0, err_addr_o}, 64'h40);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/amm_burst_master.md
# amm_burst_master

Avalon-MM burst master that drives the memory-side (`mem`) port of the `amm_if` bus under test. It accepts one command at a time to write or read-check a burst of words. The words follow a seed-based incrementing pattern. On read, every returned beat is compared against the expected pattern; the block reports the mismatch count and the address of the first bad beat. It sits between the checker control/CSR logic (command source) and the memory slave.

## Interface

Parameters:
- `ADDR_W`, 32, word-address width of `address_o` / `cmd_addr_i`
- `DATA_W`, 32, data width; must be a multiple of 8
- `BURST_W`, 11, burstcount width; legal burst length 1..2^(BURST_W-1)

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  block can accept a command (high only in IDLE)
- `cmd_op_i`  in  1  0 = write burst, 1 = read-and-check burst
- `cmd_addr_i`  in  ADDR_W  burst start word address
- `cmd_len_i`  in  BURST_W  burst length in words
- `cmd_seed_i`  in  DATA_W  pattern seed; beat k carries seed + k (mod 2^DATA_W)
- `done_o`  out  1  one-cycle pulse when a command completes
- `err_o`  out  1  at least one mismatch in the last read command
- `err_cnt_o`  out  16  mismatch count of the last read command, saturating at 0xFFFF
- `err_addr_o`  out  ADDR_W  address of the first mismatching beat
- `address_o`  out  ADDR_W  Avalon address
- `read_o`  out  1  Avalon read
- `write_o`  out  1  Avalon write
- `writedata_o`  out  DATA_W  Avalon write data
- `byteenable_o`  out  DATA_W/8  all ones whenever `write_o` or `read_o` is high, else 0
- `burstcount_o`  out  BURST_W  Avalon burstcount
- `waitrequest_i`  in  1  slave stall
- `readdata_i`  in  DATA_W  read data
- `readdatavalid_i`  in  1  read data beat valid

## Operation

- States: IDLE, WR_BURST, RD_CMD, RD_DATA, DONE.
- **IDLE:** `cmd_ready_o`=1. A command is accepted on `cmd_valid_i && cmd_ready_o`. On acceptance:
  - op, addr, len and seed are latched.
  - Beat counter is cleared.
  - For a read, `err_o`, `err_cnt_o` and `err_addr_o` are cleared.
- **Zero length:** `cmd_len_i`=0 goes IDLE -> DONE with no bus activity.
- **WR_BURST:**
  - `write_o`=1, `address_o`=start addr and `burstcount_o`=len are held constant for the whole burst.
  - `writedata_o` = seed + beat.
  - A beat is accepted when `write_o && !waitrequest_i`; beat then increments and data advances the next cycle.
  - After beat len-1 is accepted -> DONE.
- **RD_CMD:** `read_o`=1 with address/burstcount held until `!waitrequest_i`, then -> RD_DATA with `read_o`=0.
- **RD_DATA:**
  - Each `readdatavalid_i` beat is compared against seed + beat.
  - On mismatch, `err_cnt_o` increments (saturating) and `err_o` is set.
  - On the first mismatch only, `err_addr_o` is loaded with start addr + beat (mod 2^ADDR_W).
  - After beat len-1 -> DONE.
- **DONE:** `done_o`=1 for exactly one cycle -> IDLE.
- Error outputs hold until the next read command is accepted; write commands leave them untouched.
- `readdatavalid_i` outside RD_DATA is ignored. `waitrequest_i` is ignored when neither `read_o` nor `write_o` is high.

## Timing

- **Reset (async, `rst_n`=0):**
  - State -> IDLE.
  - All outputs 0 except `cmd_ready_o`, which is 1 after release.
  - An in-flight burst is abandoned; no `done_o`.
- **Write, zero wait states:** acceptance at cycle 0; `write_o` high cycles 1..len; `done_o` at cycle len+1; `cmd_ready_o` high again at cycle len+2.
- **Read, zero wait states:** `read_o` high at cycle 1 only. The comparison is registered: error outputs update the cycle after the offending beat. `done_o` comes one cycle after the last data beat.
- All Avalon outputs are registered and come directly from flops.
- **Waitrequest:** `writedata_o` is held stable while `waitrequest_i`=1. Any number of stall cycles is legal, including on the last beat.
- **Back-to-back:** the minimum gap between `done_o` and the next accepted command is one cycle (the IDLE cycle).

## Test plan

- Write, addr 0x100, len 4, seed 0xA000_0000, no wait -> `write_o` high 4 consecutive cycles with data A000_0000..A000_0003, `burstcount_o`=4, `address_o`=0x100 throughout, one `done_o` pulse.
- Write, len 3, `waitrequest_i` high 2 cycles on beat 1 -> data 1 held 3 cycles, exactly 3 beats accepted, `done_o` after beat 2.
- Read, addr 0x20, len 8, seed 5, slave returns 5..12 with gaps in `readdatavalid_i` -> `err_o`=0, `err_cnt_o`=0, `done_o` one cycle after the 8th beat.
- Read, addr 0x20, len 8, seed 5, beats 2 and 6 corrupted -> `err_cnt_o`=2, `err_addr_o`=0x22, `err_o`=1. A following write command leaves them unchanged; the next read clears them.
- `cmd_len_i`=0 -> no `read_o`/`write_o` activity, `done_o` one cycle after acceptance. Separately: `rst_n` low mid-burst (beat 2 of 6) -> all outputs 0 immediately, `cmd_ready_o`=1 after release, no `done_o`.
